camera_pixel_packer: RTL
========================

Name: camera_pixel_packer

Overview:
- Sits directly downstream of the OV5640 DVP pins and the camera capture/FIFO-reset stage, in the camera_pclk domain.
- Pairs the 8-bit DVP bytes into 16-bit RGB565 pixels and writes them into the frame FIFO that feeds the Ethernet packetiser.
- Discards start-up frames and aligns writes to clean frame boundaries.
- Reports frame/line counts, and flags FIFO overflow and malformed lines.

Parameters:
IMG_W, 640, expected pixels per line (bytes per line = 2*IMG_W)
IMG_H, 480, expected lines per frame
SKIP_FRAMES, 10, complete frames discarded after reg_conf_done before the first written frame (0 allowed)

Ports:
camera_pclk  in  1  pixel clock; sole clock
rst  in  1  synchronous, active-high reset
reg_conf_done  in  1  sensor register configuration complete (level)
camera_vsync  in  1  DVP vsync, high = blanking
camera_href  in  1  DVP href, high = valid byte
camera_data  in  8  DVP byte
fifo_full  in  1  frame FIFO full
pix_data  out  16  packed pixel {first byte, second byte}
pix_wr_en  out  1  FIFO write strobe, one per pixel
pix_sof  out  1  high with pix_wr_en on first pixel of a written frame
frame_done  out  1  1-cycle pulse at end of each written frame
frame_cnt  out  16  written frames completed, wraps 0xFFFF->0
line_cnt  out  11  lines of current frame (href falling edges), cleared at vsync high
overflow  out  1  sticky: write attempted while fifo_full
len_err  out  1  sticky: line byte count != 2*IMG_W, or frame line count != IMG_H

Behaviour:
- Reset: all outputs 0, FSM = IDLE, byte phase = 0, all counters 0. Reset overrides every other input in the same cycle.
- Input stage: vsync, href and data registered once (s1). The s1 signals are delayed once more (s2) for edge detection.
  - vs_rise = s1 & ~s2 on vsync; vs_fall = ~s1 & s2 on vsync; href_fall likewise on href.
- Byte phase:
  - Cleared whenever s1 href = 0.
  - Toggles on each s1 href = 1 cycle.
  - Phase 0 latches the high byte. Phase 1 forms the pixel.
- Latency: the second byte sampled at the pins in cycle t gives pix_data/pix_wr_en registered in cycle t+2.
- pix_data holds its last value when pix_wr_en = 0.
- FSM:
  - IDLE: go to SYNC when reg_conf_done = 1.
  - SYNC: wait for vs_rise, then go to SKIP; load skip_cnt = SKIP_FRAMES.
  - SKIP: on each vs_rise, decrement skip_cnt. At 0 (or immediately if SKIP_FRAMES = 0), go to ARM.
  - ARM: on vs_fall, go to ACTIVE and set first_pix = 1.
  - ACTIVE: a formed pixel gives pix_wr_en = 1; pix_sof = first_pix; first_pix then clears. On vs_rise, pulse frame_done, increment frame_cnt, stay ACTIVE for the next frame with first_pix = 1.
  - DROP: no writes. On vs_rise, go to ARM; no frame_done, frame_cnt unchanged.
  - reg_conf_done = 0 in any state: go to IDLE next cycle, with no write that cycle.
- Overflow:
  - A formed pixel in ACTIVE while fifo_full = 1 is not written.
  - overflow sets (sticky until rst) and the FSM goes to DROP, discarding the rest of the frame.
  - Only whole frames are delivered.
- Line check:
  - Count bytes while s1 href = 1, saturating at 2047.
  - On href_fall in ACTIVE: if count != 2*IMG_W, set len_err. An odd count leaves one dangling byte, which is discarded.
  - line_cnt increments on every href_fall in any state and saturates at 2047.
- Frame check: on vs_rise in ACTIVE, if line_cnt != IMG_H, set len_err. frame_done still pulses.
- Simultaneous events:
  - vs_rise and a formed pixel in the same cycle: the pixel is written first, then the state transition applies.
  - vs_rise and overflow together: overflow wins; go to DROP, no frame_done.
- Widths: frame_cnt is modulo 2^16. Byte counter is 11 bits with saturation. skip_cnt is sized $clog2(SKIP_FRAMES+1), minimum 1 bit.

Decomposition:
- Shared package camera_pkg:
  - FSM state encoding (IDLE, SYNC, SKIP, ARM, ACTIVE, DROP).
  - Default IMG_W/IMG_H constants.
  - RGB565 pixel width constant (16).
- One natural sub-module: dvp_edge_sync. It holds the two-stage register of vsync/href/data and outputs s1 signals plus vs_rise, vs_fall and href_fall.
- Byte pairing, FSM and checkers stay in the top level.

Test Plan:
- Reset and start-up: rst 1 for 5 cycles with reg_conf_done = 1 → all outputs 0. Drive 2 frames with SKIP_FRAMES = 2 → zero writes, frame_cnt = 0. Third frame (640x480) → exactly 307200 writes, one pix_sof, frame_done once, frame_cnt = 1.
- Byte order and latency: line bytes 0xF8,0x1F,0x07,0xE0 → pix_data 0xF81F then 0x07E0. Each pix_wr_en appears 2 cycles after its second byte is driven.
- Overflow mid-frame: assert fifo_full at line 100 pixel 10 → overflow = 1, no further writes that frame, no frame_done. Next frame is fully written with pix_sof and frame_cnt incremented by 1.
- Malformed line: one line of 1279 bytes → len_err = 1, the dangling byte is not written, 639 pixels written for that line. A 479-line frame also sets len_err.
- Config drop: reg_conf_done falls mid-line → writes stop within 1 cycle. Re-assert → SYNC; skipping restarts, and no writes occur until SKIP_FRAMES frames have passed.
- Wrap: preload or run frames to frame_cnt = 0xFFFF, then complete one frame → frame_cnt = 0x0000 and frame_done pulses.

Source files
------------

// File: rtl/camera_pkg.sv
// Shared types and constants for the camera capture path.
// FSM encoding, default geometry and RGB565 pixel width.
package camera_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SKIP,
    ARM,
    ACTIVE,
    DROP
  } state_t;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;
  localparam int PIX_W     = 16;

endpackage

// File: rtl/dvp_edge_sync.sv
// Registers the DVP pins once (s1), delays once more (s2),
// and derives vsync/href edge strobes from the pair.
module dvp_edge_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] data,
  output logic       vsync_s1,
  output logic       href_s1,
  output logic [7:0] data_s1,
  output logic       vs_rise,
  output logic       vs_fall,
  output logic       href_fall
);

  logic vsync_s2;
  logic href_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_s1 <= 1'b0;
      href_s1  <= 1'b0;
      data_s1  <= 8'h00;
      vsync_s2 <= 1'b0;
      href_s2  <= 1'b0;
    end else begin
      vsync_s1 <= vsync;
      href_s1  <= href;
      data_s1  <= data;
      vsync_s2 <= vsync_s1;
      href_s2  <= href_s1;
    end
  end

  assign vs_rise   = vsync_s1 & ~vsync_s2;
  assign vs_fall   = ~vsync_s1 & vsync_s2;
  assign href_fall = ~href_s1 & href_s2;

endmodule

// File: rtl/camera_pixel_packer.sv
// Pairs DVP bytes into RGB565 pixels, gates writes to whole
// frames after start-up skip, and tracks frame/line health.
module camera_pixel_packer
  import camera_pkg::*;
#(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int SKIP_FRAMES = 10
) (
  input  logic             camera_pclk,
  input  logic             rst,
  input  logic             reg_conf_done,
  input  logic             camera_vsync,
  input  logic             camera_href,
  input  logic [7:0]       camera_data,
  input  logic             fifo_full,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_wr_en,
  output logic             pix_sof,
  output logic             frame_done,
  output logic [15:0]      frame_cnt,
  output logic [10:0]      line_cnt,
  output logic             overflow,
  output logic             len_err
);

  localparam int SKW =
    (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [10:0] LINE_BYTES  = 11'(2 * IMG_W);
  localparam logic [10:0] FRAME_LINES = 11'(IMG_H);
  localparam logic [10:0] SAT         = 11'h7FF;

  logic             vsync_s1;
  logic             href_s1;
  logic [7:0]       data_s1;
  logic             vs_rise;
  logic             vs_fall;
  logic             href_fall;
  logic             phase;
  logic [7:0]       hi_byte;
  logic [10:0]      byte_cnt;
  logic             formed;
  logic [PIX_W-1:0] pixel;
  state_t           state;
  logic [SKW-1:0]   skip_cnt;
  logic             first_pix;

  dvp_edge_sync u_sync (
    .clk      (camera_pclk),
    .rst      (rst),
    .vsync    (camera_vsync),
    .href     (camera_href),
    .data     (camera_data),
    .vsync_s1 (vsync_s1),
    .href_s1  (href_s1),
    .data_s1  (data_s1),
    .vs_rise  (vs_rise),
    .vs_fall  (vs_fall),
    .href_fall(href_fall)
  );

  assign formed = href_s1 & phase;
  assign pixel  = {hi_byte, data_s1};

  // An odd-length line leaves its last byte in hi_byte, never paired.
  always_ff @(posedge camera_pclk) begin
    if (rst) begin
      phase    <= 1'b0;
      hi_byte  <= 8'h00;
      byte_cnt <= 11'd0;
      line_cnt <= 11'd0;
    end else begin
      phase <= href_s1 & ~phase;
      if (href_s1 && !phase)
        hi_byte <= data_s1;
      if (!href_s1)
        byte_cnt <= 11'd0;
      else if (byte_cnt != SAT)
        byte_cnt <= byte_cnt + 11'd1;
      if (vsync_s1)
        line_cnt <= 11'd0;
      else if (href_fall && line_cnt != SAT)
        line_cnt <= line_cnt + 11'd1;
    end
  end

  always_ff @(posedge camera_pclk) begin
    if (rst) begin
      state      <= IDLE;
      skip_cnt   <= '0;
      first_pix  <= 1'b0;
      pix_data   <= '0;
      pix_wr_en  <= 1'b0;
      pix_sof    <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'd0;
      overflow   <= 1'b0;
      len_err    <= 1'b0;
    end else begin
      pix_wr_en  <= 1'b0;
      pix_sof    <= 1'b0;
      frame_done <= 1'b0;
      if (!reg_conf_done) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: state <= SYNC;
          SYNC: begin
            if (vs_rise) begin
              skip_cnt <= SKW'(SKIP_FRAMES);
              state    <= (SKIP_FRAMES == 0) ? ARM : SKIP;
            end
          end
          SKIP: begin
            if (skip_cnt == '0) begin
              state <= ARM;
            end else if (vs_rise) begin
              skip_cnt <= skip_cnt - 1'b1;
              if (skip_cnt == SKW'(1))
                state <= ARM;
            end
          end
          ARM: begin
            if (vs_fall) begin
              state     <= ACTIVE;
              first_pix <= 1'b1;
            end
          end
          ACTIVE: begin
            // Overflow beats a coincident end-of-frame.
            if (formed && fifo_full) begin
              overflow <= 1'b1;
              state    <= DROP;
            end else begin
              if (formed) begin
                pix_wr_en <= 1'b1;
                pix_sof   <= first_pix;
                pix_data  <= pixel;
                first_pix <= 1'b0;
              end
              if (href_fall && byte_cnt != LINE_BYTES)
                len_err <= 1'b1;
              if (vs_rise) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + 16'd1;
                first_pix  <= 1'b1;
                if (line_cnt != FRAME_LINES)
                  len_err <= 1'b1;
              end
            end
          end
          DROP: if (vs_rise) state <= ARM;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
